// File: rtl/mux5_rr_sched.sv
// Round-robin scheduler sharing one 5:1 mux channel among five lanes.
// Bounded bursts per grant and a valid/ready handshake on the output.

module mux5x1 (
    input  logic [4:0] in,
    input  logic [2:0] sel,
    output logic       out
);
    assign out = sel[2] ? in[4] : in[sel[1:0]];
endmodule

// state | meaning
// IDLE  | no lane granted, sel holds the last lane
// GRANT | lane idx owns the channel until release or burst limit
module mux5_rr_sched #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic [4:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_data,
    output logic [2:0] sel,
    output logic [4:0] gnt,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST = 4'(MAX_BURST - 1);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [2:0] ptr, ptr_n;
    logic [3:0] cnt, cnt_n;
    logic [4:0] gnt_n;
    logic       xfer, last_beat;

    // First requesting lane scanning circularly from start.
    function automatic logic [2:0] pick(input logic [2:0] start, input logic [4:0] r);
        logic [2:0] lane;
        logic       found;
        pick  = start;
        lane  = start;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!found && r[lane]) begin
                pick  = lane;
                found = 1'b1;
            end
            lane = (lane == 3'd4) ? 3'd0 : lane + 3'd1;
        end
    endfunction

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        ptr_n     = ptr;
        cnt_n     = cnt;
        xfer      = (state == GRANT) && req[idx] && out_ready;
        last_beat = xfer && (cnt == LAST);
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    idx_n   = pick(ptr, req);
                    cnt_n   = 4'd0;
                end
            end
            GRANT: begin
                if (!req[idx] || last_beat) begin
                    ptr_n = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                    cnt_n = 4'd0;
                    if (|req) begin
                        idx_n = pick(ptr_n, req);
                    end else begin
                        state_n = IDLE;
                    end
                end else if (xfer) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = (state_n == GRANT) ? (5'b00001 << idx_n) : 5'b00000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 3'd0;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
            gnt   <= 5'b00000;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            busy  <= (state_n == GRANT);
        end
    end

    assign sel       = idx;
    assign out_valid = (state == GRANT) && req[idx];

    mux5x1 u_mux (
        .in  (in_data),
        .sel (sel),
        .out (out_data)
    );
endmodule
